// File: rtl/oxide_ff_pipe_pkg.sv
// Shared types and parameter decoders for the Oxide elastic FF pipeline.
package oxide_ff_pkg;

    localparam int MAX_WIDTH = 1024;

    typedef enum logic [1:0] {CE_ONE, CE_ZERO, CE_PASS, CE_INV} cemux_t;
    typedef enum logic {LSRM_LSR, LSRM_PRLD} lsrmode_t;
    typedef enum logic {RS_RESET, RS_SET} regset_t;

    function automatic cemux_t cemux_decode(input string s);
        if (s == "1")
            return CE_ONE;
        else if (s == "0")
            return CE_ZERO;
        else if (s == "INV")
            return CE_INV;
        return CE_PASS;
    endfunction

    function automatic lsrmode_t lsrmode_decode(input string s);
        return (s == "PRLD") ? LSRM_PRLD : LSRM_LSR;
    endfunction

    function automatic regset_t regset_decode(input string s);
        return (s == "SET") ? RS_SET : RS_RESET;
    endfunction

    // Callers truncate the MAX_WIDTH result to their own data width.
    function automatic logic [MAX_WIDTH-1:0] srval_f(input regset_t regset,
                                                     input lsrmode_t lsrmode,
                                                     input logic [MAX_WIDTH-1:0] m);
        if (lsrmode == LSRM_PRLD)
            return m;
        return (regset == RS_SET) ? '1 : '0;
    endfunction

endpackage

// File: rtl/oxide_ff_pipe_if.sv
// Valid/ready data bus of the Oxide elastic FF pipeline.
interface oxide_ff_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] DI;
    logic             DI_VALID;
    logic             DI_READY;
    logic [WIDTH-1:0] Q;
    logic             Q_VALID;
    logic             Q_READY;
    logic [CW-1:0]    COUNT;

    modport master (
        output DI, DI_VALID, Q_READY,
        input  DI_READY, Q, Q_VALID, COUNT
    );

    modport slave (
        input  DI, DI_VALID, Q_READY,
        output DI_READY, Q, Q_VALID, COUNT
    );

endinterface

// File: rtl/oxide_ff_pipe_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid bit.
module oxide_ff_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             lsr,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic [WIDTH-1:0] srval,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only moves with a valid item; bubbles leave stale data behind.
    always_ff @(posedge clk) begin
        if (lsr) begin
            data  <= srval;
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid)
                data <= src_data;
        end
    end

endmodule

// File: rtl/oxide_ff_pipe.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with Oxide CE-mux and LSR semantics.
module oxide_ff_pipe
    import oxide_ff_pkg::*;
#(
    parameter int    WIDTH   = 8,
    parameter int    DEPTH   = 4,
    parameter string CEMUX   = "CE",
    parameter string REGSET  = "RESET",
    parameter string LSRMODE = "LSR"
) (
    input  logic             CLK,
    input  logic             LSR,
    input  logic             CE,
    input  logic [WIDTH-1:0] M,
    oxide_ff_pipe_if.slave   bus
);

    localparam int       CW      = $clog2(DEPTH + 1);
    localparam cemux_t   CESEL   = cemux_decode(CEMUX);
    localparam regset_t  REGSETE = regset_decode(REGSET);
    localparam lsrmode_t LSRME   = lsrmode_decode(LSRMODE);

    logic             muxce;
    logic             run;
    logic [WIDTH-1:0] srval;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    count_q;

    always_comb begin
        muxce = 1'b0;
        case (CESEL)
            CE_ONE:  muxce = 1'b1;
            CE_ZERO: muxce = 1'b0;
            CE_PASS: muxce = CE;
            CE_INV:  muxce = ~CE;
            default: muxce = 1'b0;
        endcase
    end

    assign run   = muxce & ~LSR;
    assign srval = WIDTH'(srval_f(REGSETE, LSRME, MAX_WIDTH'(M)));

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             sv;
        logic [WIDTH-1:0] sd;

        // Unrolled form of adv[i] = ~v[i] | adv[i+1], adv[DEPTH] = Q_READY.
        assign adv[i] = ~(&v[DEPTH-1:i]) | bus.Q_READY;

        if (i == 0) begin : g_src_in
            assign sv = bus.DI_VALID;
            assign sd = bus.DI;
        end else begin : g_src_prev
            assign sv = v[i-1];
            assign sd = d[i-1];
        end

        oxide_ff_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (CLK),
            .lsr       (LSR),
            .load      (run & adv[i]),
            .src_valid (sv),
            .src_data  (sd),
            .srval     (srval),
            .valid     (v[i]),
            .data      (d[i])
        );
    end

    assign bus.DI_READY = run & adv[0];
    assign bus.Q_VALID  = run & v[DEPTH-1];
    assign bus.Q        = d[DEPTH-1];
    assign bus.COUNT    = count_q;

    assign in_xfer  = bus.DI_VALID & bus.DI_READY;
    assign out_xfer = bus.Q_VALID & bus.Q_READY;

    always_ff @(posedge CLK) begin
        if (LSR) begin
            count_q <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_oxide_ff_pipe.sv
// Directed table-driven bench for oxide_ff_pipe across three parameter sets.
module tb_oxide_ff_pipe;

    typedef struct {
        logic       lsr;
        logic       ce;
        logic       dv;
        logic [7:0] di;
        logic       qr;
        logic [7:0] m;
        logic       rdy;
        logic       qv;
        logic [7:0] q;
        logic [2:0] cnt;
    } vec_t;

    logic CLK;
    logic lsr_a, ce_a, lsr_b, ce_b, lsr_c, ce_c;
    logic [7:0] m_a, m_b, m_c;
    int n_tests;
    int n_fail;

    vec_t ta[$];
    vec_t tb[$];
    vec_t tc[$];

    oxide_ff_pipe_if #(.WIDTH(8), .DEPTH(4)) ifa ();
    oxide_ff_pipe_if #(.WIDTH(8), .DEPTH(4)) ifb ();
    oxide_ff_pipe_if #(.WIDTH(8), .DEPTH(1)) ifc ();

    oxide_ff_pipe #(.WIDTH(8), .DEPTH(4), .CEMUX("CE"), .REGSET("SET"), .LSRMODE("LSR")) u_a (
        .CLK(CLK), .LSR(lsr_a), .CE(ce_a), .M(m_a), .bus(ifa.slave));

    oxide_ff_pipe #(.WIDTH(8), .DEPTH(4), .CEMUX("1"), .REGSET("RESET"), .LSRMODE("PRLD")) u_b (
        .CLK(CLK), .LSR(lsr_b), .CE(ce_b), .M(m_b), .bus(ifb.slave));

    oxide_ff_pipe #(.WIDTH(8), .DEPTH(1), .CEMUX("INV"), .REGSET("RESET"), .LSRMODE("PRLD")) u_c (
        .CLK(CLK), .LSR(lsr_c), .CE(ce_c), .M(m_c), .bus(ifc.slave));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mk(input int lsr, input int ce, input int dv, input int di,
                                input int qr, input int m, input int rdy, input int qv,
                                input int q, input int cnt);
        vec_t r;
        r.lsr = 1'(lsr); r.ce = 1'(ce); r.dv = 1'(dv); r.di = 8'(di);
        r.qr  = 1'(qr);  r.m  = 8'(m);  r.rdy = 1'(rdy); r.qv = 1'(qv);
        r.q   = 8'(q);   r.cnt = 3'(cnt);
        return r;
    endfunction

    task automatic chk(input string tname, input int idx, input string sig,
                       input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] %s: got %h want %h", tname, idx, sig, act, exp);
        end
    endtask

    // Drive one row just after a falling edge, check before the next rising edge.
    task automatic apply(input int sel, input vec_t r, input int idx);
        logic       rdy, qv;
        logic [7:0] q;
        logic [2:0] cnt;
        string      tname;
        case (sel)
            0: begin
                lsr_a = r.lsr; ce_a = r.ce; m_a = r.m;
                ifa.DI_VALID = r.dv; ifa.DI = r.di; ifa.Q_READY = r.qr;
            end
            1: begin
                lsr_b = r.lsr; ce_b = r.ce; m_b = r.m;
                ifb.DI_VALID = r.dv; ifb.DI = r.di; ifb.Q_READY = r.qr;
            end
            default: begin
                lsr_c = r.lsr; ce_c = r.ce; m_c = r.m;
                ifc.DI_VALID = r.dv; ifc.DI = r.di; ifc.Q_READY = r.qr;
            end
        endcase
        #2;
        case (sel)
            0: begin
                tname = "d4_set"; rdy = ifa.DI_READY; qv = ifa.Q_VALID;
                q = ifa.Q; cnt = ifa.COUNT;
            end
            1: begin
                tname = "d4_prld"; rdy = ifb.DI_READY; qv = ifb.Q_VALID;
                q = ifb.Q; cnt = ifb.COUNT;
            end
            default: begin
                tname = "d1_prld"; rdy = ifc.DI_READY; qv = ifc.Q_VALID;
                q = ifc.Q; cnt = {2'b00, ifc.COUNT};
            end
        endcase
        chk(tname, idx, "DI_READY", {7'd0, rdy}, {7'd0, r.rdy});
        chk(tname, idx, "Q_VALID",  {7'd0, qv},  {7'd0, r.qv});
        chk(tname, idx, "Q",        q,           r.q);
        chk(tname, idx, "COUNT",    {5'd0, cnt}, {5'd0, r.cnt});
        @(negedge CLK);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Depth 4, CEMUX=CE, REGSET=SET: streaming, stall, bubble, CE freeze, LSR.
        //              lsr ce dv di    qr m   rdy qv q     cnt
        ta.push_back(mk(0, 1, 1, 'h01, 1, 0,  1, 0, 'hFF, 0));
        ta.push_back(mk(0, 1, 1, 'h02, 1, 0,  1, 0, 'hFF, 1));
        ta.push_back(mk(0, 1, 1, 'h03, 1, 0,  1, 0, 'hFF, 2));
        ta.push_back(mk(0, 1, 1, 'h04, 1, 0,  1, 0, 'hFF, 3));
        ta.push_back(mk(0, 1, 1, 'h05, 1, 0,  1, 1, 'h01, 4));
        ta.push_back(mk(0, 1, 1, 'h06, 1, 0,  1, 1, 'h02, 4));
        ta.push_back(mk(0, 1, 1, 'h07, 1, 0,  1, 1, 'h03, 4));
        ta.push_back(mk(0, 1, 1, 'h08, 1, 0,  1, 1, 'h04, 4));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'h05, 4));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'h06, 3));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'h07, 2));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'h08, 1));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 0, 'h08, 0));
        ta.push_back(mk(0, 1, 1, 'h11, 0, 0,  1, 0, 'h08, 0));
        ta.push_back(mk(0, 1, 1, 'h12, 0, 0,  1, 0, 'h08, 1));
        ta.push_back(mk(0, 1, 1, 'h13, 0, 0,  1, 0, 'h08, 2));
        ta.push_back(mk(0, 1, 1, 'h14, 0, 0,  1, 0, 'h08, 3));
        ta.push_back(mk(0, 1, 1, 'h15, 0, 0,  0, 1, 'h11, 4));
        ta.push_back(mk(0, 1, 1, 'h15, 1, 0,  1, 1, 'h11, 4));
        ta.push_back(mk(0, 1, 1, 'h16, 1, 0,  1, 1, 'h12, 4));
        ta.push_back(mk(0, 1, 1, 'h17, 1, 0,  1, 1, 'h13, 4));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'h14, 4));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'h15, 3));
        ta.push_back(mk(0, 1, 1, 'hA0, 0, 0,  1, 1, 'h16, 2));
        ta.push_back(mk(0, 1, 0, 'h00, 0, 0,  1, 1, 'h16, 3));
        ta.push_back(mk(0, 1, 1, 'hAA, 0, 0,  1, 1, 'h16, 3));
        ta.push_back(mk(0, 1, 1, 'hBB, 0, 0,  0, 1, 'h16, 4));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'h16, 4));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'h17, 3));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'hA0, 2));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'hAA, 1));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 0, 'hAA, 0));
        ta.push_back(mk(0, 1, 1, 'hC1, 0, 0,  1, 0, 'hAA, 0));
        ta.push_back(mk(0, 1, 1, 'hC2, 0, 0,  1, 0, 'hAA, 1));
        for (int i = 0; i < 5; i++)
            ta.push_back(mk(0, 0, 1, 'hC3, 1, 0,  0, 0, 'hAA, 2));
        ta.push_back(mk(0, 1, 0, 'h00, 0, 0,  1, 0, 'hAA, 2));
        ta.push_back(mk(0, 1, 0, 'h00, 0, 0,  1, 0, 'hAA, 2));
        ta.push_back(mk(0, 1, 0, 'h00, 0, 0,  1, 1, 'hC1, 2));
        ta.push_back(mk(0, 1, 1, 'hC3, 0, 0,  1, 1, 'hC1, 2));
        ta.push_back(mk(1, 1, 1, 'hC4, 1, 0,  0, 0, 'hC1, 3));
        ta.push_back(mk(1, 1, 1, 'hC5, 1, 0,  0, 0, 'hFF, 0));
        ta.push_back(mk(0, 1, 1, 'hC6, 1, 0,  1, 0, 'hFF, 0));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 0, 'hFF, 1));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 0, 'hFF, 1));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 0, 'hFF, 1));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 1, 'hC6, 1));
        ta.push_back(mk(0, 1, 0, 'h00, 1, 0,  1, 0, 'hC6, 0));

        // Depth 4, CEMUX="1" (CE input ignored), PRLD.
        tb.push_back(mk(1, 0, 1, 'h77, 1, 'h5C, 0, 0, 'h00, 0));
        tb.push_back(mk(0, 0, 1, 'h11, 1, 'h5C, 1, 0, 'h5C, 0));
        tb.push_back(mk(0, 0, 0, 'h00, 1, 'h33, 1, 0, 'h5C, 1));
        tb.push_back(mk(0, 0, 0, 'h00, 1, 'h33, 1, 0, 'h5C, 1));
        tb.push_back(mk(0, 0, 0, 'h00, 1, 'h33, 1, 0, 'h5C, 1));
        tb.push_back(mk(0, 0, 0, 'h00, 1, 'h33, 1, 1, 'h11, 1));
        tb.push_back(mk(0, 0, 0, 'h00, 1, 'h33, 1, 0, 'h11, 0));

        // Depth 1, CEMUX="INV", PRLD.
        tc.push_back(mk(1, 0, 0, 'h00, 0, 'hA5, 0, 0, 'h00, 0));
        tc.push_back(mk(0, 0, 1, 'h01, 1, 'hA5, 1, 0, 'hA5, 0));
        tc.push_back(mk(0, 0, 1, 'h02, 1, 'hA5, 1, 1, 'h01, 1));
        tc.push_back(mk(0, 0, 1, 'h03, 0, 'hA5, 0, 1, 'h02, 1));
        tc.push_back(mk(0, 0, 1, 'h03, 1, 'hA5, 1, 1, 'h02, 1));
        tc.push_back(mk(0, 1, 1, 'h04, 1, 'hA5, 0, 0, 'h03, 1));
        tc.push_back(mk(0, 0, 0, 'h00, 1, 'hA5, 1, 1, 'h03, 1));
        tc.push_back(mk(0, 0, 0, 'h00, 0, 'hA5, 1, 0, 'h03, 0));
        tc.push_back(mk(1, 0, 1, 'h09, 0, 'hA5, 0, 0, 'h03, 0));
        tc.push_back(mk(0, 0, 0, 'h00, 0, 'hA5, 1, 0, 'hA5, 0));

        // Common reset of all three instances, M=0 for the preload ones.
        lsr_a = 1'b1; ce_a = 1'b1; m_a = 8'h00;
        lsr_b = 1'b1; ce_b = 1'b0; m_b = 8'h00;
        lsr_c = 1'b1; ce_c = 1'b0; m_c = 8'h00;
        ifa.DI_VALID = 1'b0; ifa.DI = 8'h00; ifa.Q_READY = 1'b0;
        ifb.DI_VALID = 1'b0; ifb.DI = 8'h00; ifb.Q_READY = 1'b0;
        ifc.DI_VALID = 1'b0; ifc.DI = 8'h00; ifc.Q_READY = 1'b0;
        @(negedge CLK);
        lsr_a = 1'b0; lsr_b = 1'b0; lsr_c = 1'b0;

        foreach (ta[i]) apply(0, ta[i], i);
        foreach (tb[i]) apply(1, tb[i], i);
        foreach (tc[i]) apply(2, tc[i], i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oxide_ff_pipe.md
Name: oxide_ff_pipe

Overview:
- Parametrised successor to the single-bit Oxide FF simulation model: a WIDTH-bit, DEPTH-stage elastic register pipeline.
- Keeps the Oxide CE-mux and set/reset/preload semantics, and adds valid/ready handshaking, bubble collapse and an occupancy count.
- Used as the behavioural model for packed PFU register chains and for retiming tests in the Nexus cell library.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- CEMUX, "CE", clock-enable source: "1" = always on, "0" = never on, "CE" = CE, "INV" = ~CE.
- REGSET, "RESET", LSR value when LSRMODE="LSR": "RESET" = all zeros, "SET" = all ones.
- LSRMODE, "LSR", "LSR" = LSR loads the REGSET value; "PRLD" = LSR loads M into every stage.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- LSR  in  1  synchronous, active-high reset/set/preload.
- CE  in  1  clock enable, routed through CEMUX.
- DI  in  WIDTH  input data.
- DI_VALID  in  1  input item valid.
- DI_READY  out  1  pipeline can accept an item this cycle.
- M  in  WIDTH  preload value (used only when LSRMODE="PRLD").
- Q  out  WIDTH  last-stage data.
- Q_VALID  out  1  last stage holds a valid item.
- Q_READY  in  1  downstream accepts the item.
- COUNT  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Definitions:
  - muxce is decoded from CEMUX.
  - srval = M when LSRMODE="PRLD"; otherwise all ones for "SET", all zeros for "RESET".
  - Per stage i: data register d[i] (WIDTH bits) and valid bit v[i]. Stage 0 is the input; stage DEPTH-1 drives Q.
- Reset (LSR=1 at a rising edge):
  - every d[i] <= srval; every v[i] <= 0; COUNT -> 0.
  - LSR has priority over CE and over the handshakes.
- While LSR=1: DI_READY=0 and Q_VALID=0 (combinational), so no transfer occurs in that cycle.
- Simulation initial state: d[i]=srval (using the M value at time 0 for PRLD); v[i]=0.
- Advance chain (combinational):
  - adv[DEPTH] = Q_READY.
  - adv[i] = ~v[i] | adv[i+1].
  - Stage i loads from stage i-1 (or from DI for i=0) when muxce & ~LSR & adv[i].
- Handshakes:
  - DI_READY = muxce & ~LSR & adv[0].
  - Q_VALID = muxce & ~LSR & v[DEPTH-1].
  - Input transfer = DI_VALID & DI_READY. Output transfer = Q_VALID & Q_READY.
- Stage update on a load:
  - v[i] <= source valid (DI_VALID for stage 0).
  - d[i] <= source data only if the source is valid; otherwise d[i] holds.
  - Empty stages keep stale data; Q keeps showing stale data when Q_VALID=0.
- muxce=0: no stage changes, DI_READY=0, Q_VALID=0. Data and valids are frozen.
- Bubble collapse: an empty stage accepts from upstream even when the downstream stages are stalled.
- Latency: an item accepted at edge N into an empty pipe appears with Q_VALID=1 after edge N+DEPTH-1, i.e. DEPTH cycles from presentation to output. Throughput is one item per cycle when Q_READY=1.
- Full pipe (all v=1) with Q_READY=0: DI_READY=0.
- Full pipe with Q_READY=1: simultaneous input and output transfers; COUNT unchanged.
- COUNT:
  - +1 on an input transfer without an output transfer.
  - -1 on an output transfer without an input transfer.
  - Never exceeds DEPTH; never underflows.
  - Must always equal popcount(v).
- Ordering: items leave in arrival order; no duplication, no loss.
- DEPTH=1: single stage. DI_READY = muxce & ~LSR & (~v[0] | Q_READY).
- LSR mid-stream: all in-flight items are dropped. The first post-reset accept is possible in the cycle after LSR falls.

Decomposition:
- Package oxide_ff_pkg:
  - enum cemux_t {CE_ONE, CE_ZERO, CE_PASS, CE_INV} and a function decoding the string parameter to it.
  - enum lsrmode_t {LSRM_LSR, LSRM_PRLD}.
  - function srval_f(regset, lsrmode, m) returning the WIDTH-bit reset value.
- Sub-module oxide_ff_stage: one WIDTH-bit data register plus valid bit.
  - Inputs: load, src_valid, src_data, lsr, srval.
  - Instantiated DEPTH times through a generate loop.
  - The top level owns the advance chain, the handshakes and COUNT.

Test Plan:
1. WIDTH=8, DEPTH=4, CEMUX="1", Q_READY=1; stream DI=0x01..0x08 back-to-back -> Q_VALID first rises 4 cycles after 0x01 is presented; Q=0x01..0x08 in order, one per cycle; COUNT saturates at 4.
2. Fill 4 items with Q_READY=0 -> DI_READY=0 and COUNT=4. Then set Q_READY=1 and DI_VALID=1 for 3 cycles -> 3 in/3 out, COUNT stays 4, order preserved.
3. Insert a bubble (DI_VALID=0 for one cycle) while Q_READY=0, then push 0xAA -> bubble collapses; COUNT reaches 4 with no gap at output when draining.
4. CEMUX="CE", pipe half full, CE=0 for 5 cycles with DI_VALID=1 and Q_READY=1 -> DI_READY=0, Q_VALID=0, COUNT and all data unchanged; resumes when CE=1.
5. REGSET="SET", assert LSR mid-stream with 3 items in flight -> next cycle Q=0xFF, Q_VALID=0, COUNT=0; LSR with DI_VALID=1 accepts nothing.
6. LSRMODE="PRLD", M=0x5C, LSR pulse -> Q=0x5C with Q_VALID=0. Then push 0x11 -> Q=0x11 after DEPTH cycles. Repeat with DEPTH=1 -> single-cycle latency with full throughput.
